// File: rtl/terminal_pkg.sv
// Shared constants, cell layout and state encodings for the terminal writer.
package terminal_pkg;

    localparam int unsigned ROWS       = 30;
    localparam int unsigned COLS       = 80;
    localparam logic [7:0]  BLANK_CHAR = 8'h20;

    localparam int unsigned ROW_W  = 5;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned CLR_W  = 12;
    localparam int unsigned CELL_W = 33;

    // Cell word layout: {underline, fg, bg, char}
    localparam int unsigned UL_BIT = 32;
    localparam int unsigned FG_MSB = 31;
    localparam int unsigned FG_LSB = 20;
    localparam int unsigned BG_MSB = 19;
    localparam int unsigned BG_LSB = 8;
    localparam int unsigned CH_MSB = 7;
    localparam int unsigned CH_LSB = 0;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    localparam logic [7:0] CC_BS    = 8'h08;
    localparam logic [7:0] CC_LF    = 8'h0A;
    localparam logic [7:0] CC_FF    = 8'h0C;
    localparam logic [7:0] CC_CR    = 8'h0D;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_CLRROW
    } state_e;

    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_ADV,
        CUR_CR,
        CUR_LF,
        CUR_BS,
        CUR_HOME
    } cur_op_e;

    // Assemble a display cell word from its fields.
    function automatic logic [CELL_W-1:0] make_cell(
        input logic             ul,
        input logic [CLR_W-1:0] fg,
        input logic [CLR_W-1:0] bg,
        input logic [7:0]       ch
    );
        logic [CELL_W-1:0] w;
        w                 = '0;
        w[UL_BIT]         = ul;
        w[FG_MSB:FG_LSB]  = fg;
        w[BG_MSB:BG_LSB]  = bg;
        w[CH_MSB:CH_LSB]  = ch;
        return w;
    endfunction

endpackage

// File: rtl/terminal_cursor.sv
// Cursor position register with column advance, CR, LF, backspace, home and row wrap.
module terminal_cursor
    import terminal_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  cur_op_e          op_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             row_adv_c
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    // Next cursor position; row_adv_c flags that a new line has been entered.
    always_comb begin
        logic adv;
        row_d = row_q;
        col_d = col_q;
        adv   = 1'b0;
        unique case (op_i)
            CUR_ADV: begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    adv   = 1'b1;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            CUR_CR:  col_d = '0;
            CUR_LF: begin
                col_d = '0;
                adv   = 1'b1;
            end
            CUR_BS: begin
                if (col_q != '0) begin
                    col_d = col_q - COL_W'(1);
                end
            end
            CUR_HOME: begin
                row_d = '0;
                col_d = '0;
            end
            default: ;
        endcase
        if (adv) begin
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end
        row_adv_c = adv;
    end

    // Cursor state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o = row_q;
    assign col_o = col_q;

endmodule

// File: rtl/terminal_writer.sv
// Character stream interpreter driving the 30x80 display buffer write port.
module terminal_writer
    import terminal_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    input  logic              attr_ul,
    input  logic [CLR_W-1:0]  attr_fg,
    input  logic [CLR_W-1:0]  attr_bg,
    output logic              we,
    output logic [ROW_W-1:0]  wr,
    output logic [COL_W-1:0]  wc,
    output logic [CELL_W-1:0] wd,
    output logic [ROW_W-1:0]  cursor_row,
    output logic [COL_W-1:0]  cursor_col,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  clr_row_q, clr_row_d;
    logic [COL_W-1:0]  clr_col_q, clr_col_d;
    logic              we_q, we_d;
    logic [ROW_W-1:0]  wr_q, wr_d;
    logic [COL_W-1:0]  wc_q, wc_d;
    logic [CELL_W-1:0] wd_q, wd_d;

    logic              accept_c;
    cur_op_e           cur_op_c;
    logic              row_adv_c;
    logic [CELL_W-1:0] blank_c;

    assign char_ready = (state_q == ST_IDLE);
    assign busy       = ~char_ready;
    assign blank_c    = make_cell(1'b0, attr_fg, attr_bg, BLANK_CHAR);

    // Classify an accepted character into a cursor operation.
    always_comb begin
        accept_c = char_valid && (state_q == ST_IDLE);
        cur_op_c = CUR_NONE;
        if (accept_c) begin
            if ((char_data >= PRINT_LO) && (char_data <= PRINT_HI)) begin
                cur_op_c = CUR_ADV;
            end else begin
                unique case (char_data)
                    CC_CR:   cur_op_c = CUR_CR;
                    CC_LF:   cur_op_c = CUR_LF;
                    CC_BS:   cur_op_c = CUR_BS;
                    CC_FF:   cur_op_c = CUR_HOME;
                    default: cur_op_c = CUR_NONE;
                endcase
            end
        end
    end

    terminal_cursor u_cursor (
        .clk       (clk),
        .reset_n   (reset_n),
        .op_i      (cur_op_c),
        .row_o     (cursor_row),
        .col_o     (cursor_col),
        .row_adv_c (row_adv_c)
    );

    // Next state, clear counters and write strobe generation.
    always_comb begin
        state_d   = state_q;
        clr_row_d = clr_row_q;
        clr_col_d = clr_col_q;
        we_d      = 1'b0;
        wr_d      = wr_q;
        wc_d      = wc_q;
        wd_d      = wd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cur_op_c == CUR_ADV) begin
                    we_d = 1'b1;
                    wr_d = cursor_row;
                    wc_d = cursor_col;
                    wd_d = make_cell(attr_ul, attr_fg, attr_bg, char_data);
                end
                if ((cur_op_c == CUR_BS) && (cursor_col != '0)) begin
                    we_d = 1'b1;
                    wr_d = cursor_row;
                    wc_d = cursor_col - COL_W'(1);
                    wd_d = blank_c;
                end
                if (row_adv_c) begin
                    state_d   = ST_CLRROW;
                    clr_col_d = '0;
                end
                if (cur_op_c == CUR_HOME) begin
                    state_d   = ST_CLEAR;
                    clr_row_d = '0;
                    clr_col_d = '0;
                end
            end
            ST_CLEAR: begin
                we_d = 1'b1;
                wr_d = clr_row_q;
                wc_d = clr_col_q;
                wd_d = blank_c;
                if (clr_col_q == COL_LAST) begin
                    clr_col_d = '0;
                    if (clr_row_q == ROW_LAST) begin
                        clr_row_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        clr_row_d = clr_row_q + ROW_W'(1);
                    end
                end else begin
                    clr_col_d = clr_col_q + COL_W'(1);
                end
            end
            ST_CLRROW: begin
                we_d = 1'b1;
                wr_d = cursor_row;
                wc_d = clr_col_q;
                wd_d = blank_c;
                if (clr_col_q == COL_LAST) begin
                    clr_col_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_col_d = clr_col_q + COL_W'(1);
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_row_d = '0;
                clr_col_d = '0;
            end
        endcase
    end

    // State, counter and write-port registers; reset starts a full clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            clr_row_q <= '0;
            clr_col_q <= '0;
            we_q      <= 1'b0;
            wr_q      <= '0;
            wc_q      <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            clr_row_q <= clr_row_d;
            clr_col_q <= clr_col_d;
            we_q      <= we_d;
            wr_q      <= wr_d;
            wc_q      <= wc_d;
            wd_q      <= wd_d;
        end
    end

    assign we = we_q;
    assign wr = wr_q;
    assign wc = wc_q;
    assign wd = wd_q;

endmodule

// File: tb/tb_terminal_writer.sv
// Directed self-checking bench for terminal_writer.
module tb_terminal_writer;

    localparam int NROWS = 30;
    localparam int NCOLS = 80;

    logic        clk;
    logic        reset_n;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        attr_ul;
    logic [11:0] attr_fg;
    logic [11:0] attr_bg;
    logic        we;
    logic [4:0]  wr;
    logic [6:0]  wc;
    logic [32:0] wd;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    terminal_writer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .attr_ul    (attr_ul),
        .attr_fg    (attr_fg),
        .attr_bg    (attr_bg),
        .we         (we),
        .wr         (wr),
        .wc         (wc),
        .wd         (wd),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] blank_w();
        return {1'b0, attr_fg, attr_bg, 8'h20};
    endfunction

    function automatic logic [32:0] cell_w(input logic [7:0] ch);
        return {attr_ul, attr_fg, attr_bg, ch};
    endfunction

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (char_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("ready_wait", 64'(char_ready), 64'(1));
    endtask

    task automatic send_char(input logic [7:0] c);
        wait_ready(3000);
        char_data  = c;
        char_valid = 1'b1;
        tick();
        char_valid = 1'b0;
    endtask

    task automatic chk_cursor(input string tag, input int r, input int c);
        chk(tag, 64'({cursor_row, cursor_col}), 64'({5'(r), 7'(c)}));
    endtask

    // Follow a single-row clear from just after the triggering edge.
    task automatic check_clrrow(input string tag, input int row);
        int cnt;
        int bad;
        cnt = 0;
        bad = 0;
        while (char_ready !== 1'b1 && cnt < 200) begin
            tick();
            if (!(we === 1'b1 && wr === 5'(row) && wc === 7'(cnt) && wd === blank_w())) bad++;
            cnt++;
        end
        chk({tag, "_bad_strobes"}, 64'(bad), 64'(0));
        chk({tag, "_busy_cycles"}, 64'(cnt), 64'(NCOLS));
        tick();
        chk({tag, "_we_after"}, 64'(we), 64'(0));
    endtask

    // Follow a whole-screen clear of n steps starting at (0,0).
    task automatic check_clear(input string tag, input int steps);
        int bad;
        int r;
        int c;
        bad = 0;
        r = 0;
        c = 0;
        for (int k = 0; k < steps; k++) begin
            tick();
            if (!(we === 1'b1 && wr === 5'(r) && wc === 7'(c) && wd === blank_w())) bad++;
            if (k < NROWS * NCOLS - 1 && char_ready !== 1'b0) bad++;
            c++;
            if (c == NCOLS) begin
                c = 0;
                r++;
            end
        end
        chk({tag, "_bad_strobes"}, 64'(bad), 64'(0));
    endtask

    initial begin
        reset_n    = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        attr_ul    = 1'b0;
        attr_fg    = 12'h123;
        attr_bg    = 12'h456;

        // Reset state
        tick();
        tick();
        chk("rst_we", 64'(we), 64'(0));
        chk("rst_wr_wc", 64'({wr, wc}), 64'(0));
        chk("rst_wd", 64'(wd), 64'(0));
        chk_cursor("rst_cursor", 0, 0);
        chk("rst_ready", 64'({char_ready, busy}), 64'(2'b01));
        reset_n = 1'b1;

        // Power-up clear: 2400 strobes then ready
        check_clear("pwr_clear", NROWS * NCOLS);
        chk("pwr_clear_ready", 64'(char_ready), 64'(1));
        chk_cursor("pwr_clear_cursor", 0, 0);
        tick();
        chk("pwr_clear_we_after", 64'(we), 64'(0));

        // Single printable character
        attr_ul = 1'b1;
        attr_fg = 12'hFFF;
        attr_bg = 12'h000;
        send_char(8'h41);
        chk("A_we", 64'(we), 64'(1));
        chk("A_wr_wc", 64'({wr, wc}), 64'(0));
        chk("A_wd", 64'(wd), 64'(33'h1_FFF0_0041));
        chk_cursor("A_cursor", 0, 1);
        chk("A_ready", 64'(char_ready), 64'(1));
        tick();
        chk("A_we_pulse", 64'(we), 64'(0));

        // Move to (5,0) with line feeds
        for (int i = 0; i < 5; i++) send_char(8'h0A);
        wait_ready(200);
        chk_cursor("lf5_cursor", 5, 0);

        // 80 back-to-back characters fill row 5 and wrap into a clear of row 6
        begin
            int bad;
            bad = 0;
            char_data  = 8'h78;
            char_valid = 1'b1;
            for (int i = 0; i < NCOLS; i++) begin
                tick();
                if (!(we === 1'b1 && wr === 5'd5 && wc === 7'(i) && wd === cell_w(8'h78))) bad++;
                if (i < NCOLS - 1 && char_ready !== 1'b1) bad++;
            end
            char_valid = 1'b0;
            chk("burst_bad_writes", 64'(bad), 64'(0));
            chk_cursor("burst_cursor", 6, 0);
            chk("burst_ready_low", 64'(char_ready), 64'(0));
            check_clrrow("burst_clrrow", 6);
            chk_cursor("burst_cursor_after", 6, 0);
        end

        // Bottom row wrap: (29,10) + LF -> (0,0), row 0 cleared
        for (int i = 0; i < 23; i++) send_char(8'h0A);
        for (int i = 0; i < 10; i++) send_char(8'(8'h30 + i));
        chk_cursor("row29_cursor", 29, 10);
        send_char(8'h0A);
        chk("wrap_lf_we", 64'(we), 64'(0));
        chk_cursor("wrap_lf_cursor", 0, 0);
        chk("wrap_lf_ready", 64'(char_ready), 64'(0));
        check_clrrow("wrap_clrrow", 0);

        // Backspace at (2,7) blanks (2,6)
        send_char(8'h0A);
        send_char(8'h0A);
        for (int i = 0; i < 7; i++) send_char(8'h61);
        chk_cursor("bs_pre_cursor", 2, 7);
        attr_fg = 12'hABC;
        attr_bg = 12'hDEF;
        send_char(8'h08);
        chk("bs_we", 64'(we), 64'(1));
        chk("bs_wr_wc", 64'({wr, wc}), 64'({5'd2, 7'd6}));
        chk("bs_wd", 64'(wd), 64'(33'h0_ABCD_EF20));
        chk_cursor("bs_cursor", 2, 6);

        // Ignored codes: accepted, no write, cursor unchanged
        send_char(8'h07);
        chk("bel_we", 64'(we), 64'(0));
        chk_cursor("bel_cursor", 2, 6);
        chk("bel_ready", 64'(char_ready), 64'(1));
        send_char(8'h7F);
        chk("del_we", 64'(we), 64'(0));
        send_char(8'h80);
        chk("x80_we", 64'(we), 64'(0));
        send_char(8'h1F);
        chk("x1f_we", 64'(we), 64'(0));
        chk_cursor("ignored_cursor", 2, 6);

        // Printable range boundaries on row 3
        send_char(8'h0A);
        send_char(8'h20);
        chk("sp_we", 64'(we), 64'(1));
        chk("sp_wr_wc", 64'({wr, wc}), 64'({5'd3, 7'd0}));
        chk("sp_wd", 64'(wd), 64'(33'h1_ABCD_EF20));
        send_char(8'h7E);
        chk("tilde_wd", 64'(wd), 64'(33'h1_ABCD_EF7E));
        chk("tilde_wc", 64'(wc), 64'(1));
        for (int i = 0; i < 38; i++) send_char(8'h2E);
        chk_cursor("cr_pre_cursor", 3, 40);

        // CR, then BS at column 0
        send_char(8'h0D);
        chk("cr_we", 64'(we), 64'(0));
        chk_cursor("cr_cursor", 3, 0);
        send_char(8'h08);
        chk("bs0_we", 64'(we), 64'(0));
        chk_cursor("bs0_cursor", 3, 0);
        chk("bs0_ready", 64'(char_ready), 64'(1));

        // Form feed, reset during clear, clear restarts from (0,0)
        send_char(8'h0C);
        chk("ff_we", 64'(we), 64'(0));
        chk_cursor("ff_cursor", 0, 0);
        chk("ff_ready", 64'(char_ready), 64'(0));
        check_clear("ff_partial", 1000);
        reset_n = 1'b0;
        #1;
        chk("midrst_we", 64'(we), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(1));
        tick();
        tick();
        reset_n = 1'b1;
        check_clear("restart_clear", NROWS * NCOLS);
        chk("restart_ready", 64'(char_ready), 64'(1));
        chk_cursor("restart_cursor", 0, 0);
        tick();
        chk("restart_we_after", 64'(we), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/terminal_writer.md
Name: terminal_writer

Overview:
Upstream writer for the 30x80 character display buffer. It accepts a byte stream of ASCII characters over a valid/ready handshake and interprets printable codes and a small set of control codes. It maintains the cursor and issues write strobes (row, col, 33-bit cell word) into the display buffer's write port. It also performs whole-screen and single-row clears as multi-cycle operations.

Parameters:
ROWS, 30, number of text rows (must be 32 or fewer)
COLS, 80, number of text columns (must be 128 or fewer)
BLANK_CHAR, 8'h20, character code written by clear and backspace operations

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
char_valid  input  1  char_data is valid
char_data  input  8  ASCII code
char_ready  output  1  writer can accept a character this cycle
attr_ul  input  1  underline attribute for printable characters
attr_fg  input  12  foreground colour for printable characters and blanks
attr_bg  input  12  background colour for printable characters and blanks
we  output  1  display buffer write strobe
wr  output  5  write row
wc  output  7  write column
wd  output  33  write data, {underline, fg[11:0], bg[11:0], charCode[7:0]}
cursor_row  output  5  current cursor row
cursor_col  output  7  current cursor column
busy  output  1  a clear operation is in progress

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low on reset_n. Every flop clears on reset.
- Reset values: we=0, wr=0, wc=0, wd=0, cursor_row=0, cursor_col=0. The state machine resets into CLEAR with its clear counter at 0.
- Registered outputs: we, wr, wc and wd are registered. char_ready = (state==IDLE), decoded combinationally from the state register. busy = !char_ready.
- Handshake: a character is accepted on a rising edge where char_valid && char_ready. The write it produces appears on we/wr/wc/wd after that same edge (1-cycle latency) and lasts exactly one cycle. Sustained throughput is one character per cycle while no clear is triggered.
- Blank word: {1'b0, attr_fg, attr_bg, BLANK_CHAR}, sampled when the word is issued.
- States:
  - IDLE: accepts characters.
  - CLEAR: whole-screen clear.
  - CLRROW: single-row clear of the current cursor row.
- Printable characters (0x20-0x7E):
  - Write {attr_ul, attr_fg, attr_bg, char} at (cursor_row, cursor_col), then cursor_col+1.
  - If cursor_col was COLS-1: cursor_col=0 and a row advance follows.
- Row advance:
  - cursor_row+1, wrapping from ROWS-1 to 0.
  - Then enter CLRROW for the new row (circular screen; the newest line is always blank).
- Control codes:
  - 0x0D CR: cursor_col=0.
  - 0x0A LF: cursor_col=0, then row advance.
  - 0x08 BS: if cursor_col>0, cursor_col-1 and write a blank at the new position. At col 0 it is a no-op and the cursor stays put.
  - 0x0C FF: cursor to (0,0), enter CLEAR.
  - All other codes, including 0x7F and codes 0x80 and above: accepted, no write, no cursor change.
- CLRROW:
  - One write per cycle of the blank word at (cursor_row, 0..COLS-1): COLS strobes.
  - Returns to IDLE on the same edge that registers the last strobe. The cursor is unchanged during the clear.
- CLEAR:
  - One write per cycle of the blank word, row-major from (0,0) to (ROWS-1, COLS-1): ROWS*COLS = 2400 strobes.
  - Returns to IDLE on the edge that registers the last strobe.
  - From reset release, the first strobe is registered at edge 1 and char_ready goes high after edge 2400.
- Clear counters: separate row/col counters. No multiply; col wraps at COLS-1 into a row increment.
- Reset mid-operation: reset_n low at any point aborts the operation. we drops immediately, and CLEAR restarts from (0,0) after release.
- While in CLEAR or CLRROW, char_valid is ignored (char_ready=0). The upstream source must hold its data.

Decomposition:
- Shared package terminal_pkg:
  - ROWS, COLS, BLANK_CHAR constants.
  - Cell field widths and bit positions: UL_BIT=32, FG=[31:20], BG=[19:8], CH=[7:0].
  - Control code constants: CR, LF, BS, FF.
  - State enum: IDLE, CLEAR, CLRROW.
- Sub-module terminal_cursor: holds cursor_row/col and implements advance, CR, BS, home and row-advance wrap. It gives a clean unit for the wrap boundary checks.

Test Plan:
- Reset release, char_valid=0 -> 2400 consecutive we pulses covering (0,0)..(29,79) with wd=blank. char_ready rises after edge 2400 and cursor=(0,0).
- Send 'A' (0x41) with ul=1, fg=12'hFFF, bg=12'h000 -> one cycle later we=1, wr=0, wc=0, wd=33'h1_FFF0_0041. cursor_col=1, char_ready stays 1.
- 80 back-to-back 'x' from (5,0) -> 80 writes, then cursor=(6,0). char_ready drops for exactly 80 cycles of CLRROW writing blanks to row 6.
- Cursor at (29,10), send LF -> cursor=(0,0), CLRROW on row 0. CR at (3,40) -> (3,0) with no write. BS at (3,0) -> no write, cursor unchanged.
- BS at (2,7) -> write blank at (2,6), cursor=(2,6). Send 0x07 -> accepted, no we, cursor unchanged.
- FF mid-stream, then assert reset_n=0 at clear step 1000 -> we=0 immediately. After release, CLEAR restarts at (0,0) and completes 2400 writes.
